regfile_wb_arbiter: RTL and testbench

Write-port arbiter for the 32x32 register file. It shares the file's single write port (writeRegister / writeData / RegWrite) among NUM_SRC writeback sources: src0 is the ALU, src1 is the load unit and src2 is the mult/div unit. Each source uses a valid/ready handshake. The block grants at most one write per cycle and presents it on registered outputs that connect directly to the register file, which samples on the same clock edge.

---
 rtl/regfile_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter that shares the register file's single write port among NUM_SRC writeback sources.
// Define REGFILE_ARB_STARVE_EN to compile in starvation counters and promotion; otherwise selection is pure fixed priority.
module regfile_wb_arbiter #(
    parameter int NUM_SRC      = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_SRC-1:0]               src_valid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    src_reg,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_data,
    output logic [NUM_SRC-1:0]               src_ready,
    output logic [ADDR_WIDTH-1:0]            writeRegister,
    output logic [DATA_WIDTH-1:0]            writeData,
    output logic                             RegWrite,
    output logic [2:0]                       grant_id
);

    logic [NUM_SRC-1:0]    starved;
    logic [NUM_SRC-1:0]    grant;
    logic                  anyGrant;
    logic [2:0]            grantIdx;
    logic [ADDR_WIDTH-1:0] selReg;
    logic [DATA_WIDTH-1:0] selData;

    logic [ADDR_WIDTH-1:0] writeRegister_q, writeRegister_d;
    logic [DATA_WIDTH-1:0] writeData_q, writeData_d;
    logic                  regWrite_q, regWrite_d;
    logic [2:0]            grantId_q, grantId_d;

`ifdef REGFILE_ARB_STARVE_EN
    logic [3:0] starveCnt_q [NUM_SRC];
    logic [3:0] starveCnt_d [NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            starved[i] = (starveCnt_q[i] == 4'(STARVE_LIMIT));
        end
    end

    // Counters saturate at the limit and restart whenever the source is idle or served.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!src_valid[i] || grant[i]) begin
                starveCnt_d[i] = '0;
            end else if (starved[i]) begin
                starveCnt_d[i] = starveCnt_q[i];
            end else begin
                starveCnt_d[i] = starveCnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                starveCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                starveCnt_q[i] <= starveCnt_d[i];
            end
        end
    end
`else
    // STARVE_LIMIT has no role in the fixed-priority build.
    logic unusedStarveLimit;
    assign unusedStarveLimit = ^4'(STARVE_LIMIT);
    assign starved           = '0;
`endif

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!anyGrant && src_valid[i] && starved[i]) begin
                grant[i] = 1'b1;
                grantIdx = 3'(i);
                anyGrant = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!anyGrant && src_valid[i]) begin
                grant[i] = 1'b1;
                grantIdx = 3'(i);
                anyGrant = 1'b1;
            end
        end
    end

    assign src_ready = reset_n ? grant : '0;

    always_comb begin
        selReg  = '0;
        selData = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                selReg  = src_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
                selData = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A $zero destination still consumes the slot but must not produce a write pulse.
    always_comb begin
        writeRegister_d = writeRegister_q;
        writeData_d     = writeData_q;
        grantId_d       = grantId_q;
        regWrite_d      = 1'b0;
        if (anyGrant) begin
            writeRegister_d = selReg;
            writeData_d     = selData;
            grantId_d       = grantIdx;
            regWrite_d      = (selReg != '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            writeRegister_q <= '0;
            writeData_q     <= '0;
            regWrite_q      <= 1'b0;
            grantId_q       <= '0;
        end else begin
            writeRegister_q <= writeRegister_d;
            writeData_q     <= writeData_d;
            regWrite_q      <= regWrite_d;
            grantId_q       <= grantId_d;
        end
    end

    assign writeRegister = writeRegister_q;
    assign writeData     = writeData_q;
    assign RegWrite      = regWrite_q;
    assign grant_id      = grantId_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a request-level source model predicts each grant and the registered write.
// Honours REGFILE_ARB_STARVE_EN so the same bench covers both builds.
module tb_regfile_wb_arbiter;

    localparam int NS    = 3;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NS-1:0]   src_valid;
    logic [NS*AW-1:0] src_reg;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]   src_ready;
    logic [AW-1:0]   writeRegister;
    logic [DW-1:0]   writeData;
    logic            RegWrite;
    logic [2:0]      grant_id;

    regfile_wb_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .src_valid(src_valid), .src_reg(src_reg), .src_data(src_data),
        .src_ready(src_ready), .writeRegister(writeRegister), .writeData(writeData),
        .RegWrite(RegWrite), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rg;
        logic [DW-1:0] dt;
        logic [2:0]    id;
    } expect_t;

    expect_t sbq[$];
    int nVectors = 0;
    int nMiscompares = 0;

    // Request-level picture of each source: an outstanding request and how long it has lost in a row.
    bit            pend[NS];
    logic [AW-1:0] pendReg[NS];
    logic [DW-1:0] pendData[NS];
    int            lostCycles[NS];
    logic [AW-1:0] lastReg;
    logic [DW-1:0] lastData;
    logic [2:0]    lastId;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isStarved(input int s);
`ifdef REGFILE_ARB_STARVE_EN
        return lostCycles[s] >= LIMIT;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pickWinner();
        for (int s = 0; s < NS; s++) if (pend[s] && isStarved(s)) return s;
        for (int s = 0; s < NS; s++) if (pend[s]) return s;
        return -1;
    endfunction

    // One cycle of stimulus: sources without an outstanding request may raise a new one.
    task automatic applyStimulus(input logic [NS-1:0] want, input logic [NS*AW-1:0] regs, input logic [NS*DW-1:0] datas);
        int g;
        expect_t e;
        @(negedge clock);
        for (int s = 0; s < NS; s++) begin
            if (!pend[s] && want[s]) begin
                pend[s]     = 1'b1;
                pendReg[s]  = regs[s*AW +: AW];
                pendData[s] = datas[s*DW +: DW];
            end
            src_valid[s]          = pend[s];
            src_reg[s*AW +: AW]   = pend[s] ? pendReg[s]  : AW'($urandom);
            src_data[s*DW +: DW]  = pend[s] ? pendData[s] : $urandom;
        end
        #1;
        g = pickWinner();
        checkOutput("src_ready", 32'(src_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
            lastReg  = pendReg[g];
            lastData = pendData[g];
            lastId   = 3'(g);
            e.we     = (pendReg[g] != '0);
        end else begin
            e.we = 1'b0;
        end
        e.rg = lastReg;
        e.dt = lastData;
        e.id = lastId;
        sbq.push_back(e);
        for (int s = 0; s < NS; s++) begin
            if (pend[s] && s != g) lostCycles[s] = (lostCycles[s] < LIMIT) ? lostCycles[s] + 1 : LIMIT;
            else                   lostCycles[s] = 0;
        end
        if (g >= 0) pend[g] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus('0, '0, '0);
    endtask

    // Asserts reset away from the clock edge; outstanding requests stay asserted and are re-arbitrated afterwards.
    task automatic doReset(input bit midStream);
        if (midStream) begin
            @(posedge clock);
            #2;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("rst_RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("rst_writeRegister", 32'(writeRegister), 32'd0);
        checkOutput("rst_writeData", writeData, 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_src_ready", 32'(src_ready), 32'd0);
        sbq.delete();
        for (int s = 0; s < NS; s++) lostCycles[s] = 0;
        lastReg  = '0;
        lastData = '0;
        lastId   = '0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n && sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("RegWrite", 32'(RegWrite), 32'(e.we));
                checkOutput("writeRegister", 32'(writeRegister), 32'(e.rg));
                checkOutput("writeData", writeData, e.dt);
                checkOutput("grant_id", 32'(grant_id), 32'(e.id));
            end
        end
    end

    initial begin
        logic [NS*AW-1:0] rr;
        logic [NS*DW-1:0] dd;
        reset_n   = 1'b1;
        src_valid = '0;
        src_reg   = '0;
        src_data  = '0;
        for (int s = 0; s < NS; s++) begin
            pend[s] = 1'b0; pendReg[s] = '0; pendData[s] = '0; lostCycles[s] = 0;
        end
        lastReg = '0; lastData = '0; lastId = '0;
        #3;
        doReset(1'b0);

        applyStimulus(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0});
        idle(2);

        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
        idle(4);

        applyStimulus(3'b101, {5'd9, 5'd0, 5'd4}, {32'h22222222, 32'd0, $urandom});
        repeat (10) applyStimulus(3'b001, {5'd0, 5'd0, 5'd4}, {64'd0, $urandom});
        idle(3);

        applyStimulus(3'b001, {10'd0, 5'd0}, {64'd0, 32'h12345678});
        idle(2);

        applyStimulus(3'b110, {5'd12, 5'd11, 5'd0}, {32'h55555555, 32'h44444444, 32'd0});
        doReset(1'b1);
        idle(3);

        for (int k = 0; k < 400; k++) begin
            for (int s = 0; s < NS; s++) begin
                rr[s*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
                dd[s*DW +: DW] = $urandom;
            end
            applyStimulus(NS'($urandom), rr, dd);
            if (k == 200) doReset(1'b1);
        end
        idle(4);

        repeat (2) @(posedge clock);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
